// File: rtl/pingpong_wr_ctrl.sv
// Ping-pong bank write controller: fills one group buffer while the reader owns
// the other, counting dropped words (oOvf) and reader/writer bank collisions (oCol).
module pingpong_wr_ctrl #(
    parameter int GRP_LEN = 1024,
    parameter int DW      = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [15:0]   iWord,
    input  logic          iValid,
    input  logic          iSync,
    input  logic          iRdSel,
    output logic [9:0]    oAddr,
    output logic [DW-1:0] oData,
    output logic          oWe0,
    output logic          oWe1,
    output logic          oReady,
    output logic          oBank,
    output logic [7:0]    oOvf,
    output logic [7:0]    oCol
);

    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

    localparam logic [9:0] LAST = 10'(GRP_LEN - 1);

    state_t          state_q, state_d;
    logic [9:0]      cnt_q, cnt_d;
    logic            wbank_q, wbank_d;
    logic [9:0]      addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic            we_q, we_d;
    logic            rdy_q, rdy_d;
    logic [7:0]      ovf_q, ovf_d;
    logic [7:0]      col_q, col_d;
    logic            wr_ok;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wbank_d = wbank_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        rdy_d   = 1'b0;
        ovf_d   = ovf_q;
        col_d   = col_q;
        case (state_q)
            IDLE: begin
                if (iSync) begin
                    wbank_d = ~iRdSel;
                    cnt_d   = '0;
                    state_d = FILL;
                    if (iValid) begin
                        we_d   = 1'b1;
                        addr_d = '0;
                        data_d = iWord[DW-1:0];
                        cnt_d  = 10'd1;
                    end
                end
            end
            FILL: begin
                // Reader grabbed the bank we are filling: drop the group entirely.
                if (iRdSel == wbank_q) begin
                    col_d   = (col_q == 8'hFF) ? col_q : col_q + 8'd1;
                    state_d = IDLE;
                end else if (iSync) begin
                    cnt_d = '0;
                    if (iValid) begin
                        we_d   = 1'b1;
                        addr_d = '0;
                        data_d = iWord[DW-1:0];
                        cnt_d  = 10'd1;
                    end
                end else if (iValid) begin
                    we_d   = 1'b1;
                    addr_d = cnt_q;
                    data_d = iWord[DW-1:0];
                    if (cnt_q == LAST) begin
                        rdy_d   = 1'b1;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
            end
            HOLD: begin
                if (iValid) ovf_d = (ovf_q == 8'hFF) ? ovf_q : ovf_q + 8'd1;
                if (iRdSel == wbank_q) begin
                    wbank_d = ~wbank_q;
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wbank_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            rdy_q   <= 1'b0;
            ovf_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wbank_q <= wbank_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            rdy_q   <= rdy_d;
            ovf_q   <= ovf_d;
            col_q   <= col_d;
        end
    end

    // The registered write lands a cycle late; mask it if the reader swapped onto that bank meanwhile.
    assign wr_ok  = we_q & (iRdSel != wbank_q);
    assign oWe0   = wr_ok & ~wbank_q;
    assign oWe1   = wr_ok & wbank_q;
    assign oReady = rdy_q & (iRdSel != wbank_q);
    assign oAddr  = addr_q;
    assign oData  = data_q;
    assign oBank  = wbank_q;
    assign oOvf   = ovf_q;
    assign oCol   = col_q;

    generate
        if (DW < 16) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^iWord[15:DW];
        end
    endgenerate

endmodule

// File: doc/pingpong_wr_ctrl.md
PINGPONG_WR_CTRL -- requirements
Module: pingpong_wr_ctrl

Interface
REQ-001 The block SHALL have parameter GRP_LEN, default 1024, meaning words per group buffer (2..1024).
REQ-002 The block SHALL have parameter DW, default 12, meaning buffer word width.
REQ-003 The block SHALL have port clk, input, 1, meaning the single system clock for all logic.
REQ-004 The block SHALL have port reset, input, 1, meaning synchronous active-low reset sampled on rising clk.
REQ-005 The block SHALL have port iWord, input, 16, meaning receiver word; bits [DW-1:0] are stored.
REQ-006 The block SHALL have port iValid, input, 1, meaning single-cycle strobe qualifying iWord.
REQ-007 The block SHALL have port iSync, input, 1, meaning single-cycle frame/group start marker.
REQ-008 The block SHALL have port iRdSel, input, 1, meaning bank currently owned by the frame reader (0 = m0, 1 = m1).
REQ-009 The block SHALL have port oAddr, output, 10, meaning write address shared by both banks.
REQ-010 The block SHALL have port oData, output, DW, meaning write data shared by both banks.
REQ-011 The block SHALL have ports oWe0 and oWe1, output, 1 each, meaning write enables for banks m0 and m1.
REQ-012 The block SHALL have port oReady, output, 1, meaning single-cycle pulse when a bank holds a complete group.
REQ-013 The block SHALL have port oBank, output, 1, meaning bank currently targeted for writing.
REQ-014 The block SHALL have ports oOvf and oCol, output, 8 each, meaning saturating counts of dropped words and bank collisions.

Function
REQ-015 The FSM SHALL have states IDLE, FILL and HOLD.
REQ-016 In IDLE, iValid without iSync SHALL be discarded and SHALL NOT count as overflow.
REQ-017 In IDLE, iSync SHALL latch wbank = ~iRdSel, clear the word counter and enter FILL.
REQ-018 In FILL, each iValid SHALL produce, on the next cycle, oAddr = counter, oData = iWord[DW-1:0] and a one-cycle pulse on oWe0 (wbank = 0) or oWe1 (wbank = 1), then increment the counter; write latency is exactly 1 clk.
REQ-019 oWe0 and oWe1 SHALL never be high in the same cycle, and SHALL never target the bank equal to iRdSel at the time of the write.
REQ-020 When the GRP_LEN-th word is written, the block SHALL pulse oReady in the same cycle as that write and enter HOLD.
REQ-021 In HOLD, each iValid SHALL be dropped and increment oOvf, saturating at 255.
REQ-022 In HOLD, iSync SHALL be ignored.
REQ-023 When iRdSel == wbank is sampled in HOLD (reader took the filled bank), the block SHALL set wbank = ~wbank, clear the counter and enter FILL on the next cycle.
REQ-024 An iValid in that same cycle SHALL be dropped and counted in oOvf.
REQ-025 iSync in FILL with counter != 0 SHALL abandon the partial group and restart at address 0 in the same bank, without pulsing oReady.
REQ-026 If iSync and iValid coincide in FILL, the sync SHALL apply first and the word SHALL be written at address 0.
REQ-027 If iRdSel becomes equal to wbank while in FILL (reader swapped early), the block SHALL suppress any write in that cycle, increment oCol (saturating at 255) and return to IDLE.
REQ-028 The counter width SHALL be 10 bits; comparison SHALL use GRP_LEN-1, and the counter SHALL NOT wrap within a group.
REQ-029 oBank SHALL equal wbank.

Reset
REQ-030 When reset = 0 at a rising clk edge, the state SHALL become IDLE, and the counter, wbank, oAddr, oData, oWe0, oWe1, oReady, oOvf and oCol SHALL all become 0.
REQ-031 Reset asserted mid-FILL SHALL suppress any pending write in the following cycle.

Verification
REQ-032 iRdSel=0, iSync, then 1024 iValid words 0..1023 -> oWe1 pulses at addresses 0..1023 with matching data, no oWe0, a single oReady with the last write, state HOLD.
REQ-033 From HOLD with wbank=1, drive 5 iValid -> oOvf=5, no writes; then set iRdSel=1 -> next words are written to m0 starting at address 0.
REQ-034 GRP_LEN=4, iSync with iValid after 2 words -> data written at address 0, the word count restarts, no oReady.
REQ-035 In FILL of bank 1, set iRdSel=1 -> oCol=1, no write that cycle, state IDLE; the next iSync selects bank 0.
REQ-036 Drive 300 words in HOLD -> oOvf saturates at 255.
REQ-037 Assert reset after 10 FILL writes -> all outputs 0; words without iSync are discarded with oOvf unchanged.
